// File: rtl/reg_bus_master.sv
// Register-bus initiator: turns valid/ready read/write commands into active-low
// select / write-enable strobes for a bank of tri-state register targets.
module reg_bus_master #(
    parameter int WIDTH   = 16,
    parameter int NREGS   = 4,
    parameter int ADDR_W  = 2,
    parameter int RD_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [WIDTH-1:0]  cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              busy,
    output logic [NREGS-1:0]  bus_sel_n,
    output logic              bus_we_n,
    output logic [WIDTH-1:0]  bus_wdata,
    input  logic [WIDTH-1:0]  bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_TURN
    } state_t;

    state_t             state_q;
    logic [2:0]         cnt_q;
    logic               cmd_ready_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic [WIDTH-1:0]   rsp_rdata_q;
    logic               busy_q;
    logic [NREGS-1:0]   bus_sel_n_q;
    logic               bus_we_n_q;
    logic [WIDTH-1:0]   bus_wdata_q;

    logic               addr_ok_d;
    logic [NREGS-1:0]   sel_n_d;

    assign addr_ok_d = (32'(cmd_addr) < 32'(NREGS));

    // NOTE: give every combinational output a default before any branch so no latch is inferred.
    always_comb begin
        sel_n_d = '1;
        for (int i = 0; i < NREGS; i++) begin
            if (32'(cmd_addr) == 32'(i)) begin
                sel_n_d[i] = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            bus_sel_n_q <= '1;
            bus_we_n_q  <= 1'b1;
            bus_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (!addr_ok_d) begin
                            // Out-of-range: skip the bus entirely and respond straight from TURN.
                            state_q     <= S_TURN;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else if (cmd_we) begin
                            state_q     <= S_WRITE;
                            bus_sel_n_q <= sel_n_d;
                            bus_we_n_q  <= 1'b0;
                            bus_wdata_q <= cmd_wdata;
                        end else begin
                            state_q     <= S_READ;
                            bus_sel_n_q <= sel_n_d;
                            cnt_q       <= 3'(RD_WAIT);
                        end
                    end
                end
                S_WRITE: begin
                    state_q     <= S_TURN;
                    bus_sel_n_q <= '1;
                    bus_we_n_q  <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                S_READ: begin
                    if (cnt_q == 3'd0) begin
                        state_q     <= S_TURN;
                        bus_sel_n_q <= '1;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= bus_rdata;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_TURN: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    bus_sel_n_q <= '1;
                    bus_we_n_q  <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;
    assign bus_sel_n = bus_sel_n_q;
    assign bus_we_n  = bus_we_n_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench: three masters (RD_WAIT 0/2/3, NREGS 4/3/4) each driving a
// behavioural bank of tri-state register targets.
module tb_reg_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_we = 1'b0;
    logic [1:0]  cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic        valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;

    logic        ready_a, rv_a, re_a, busy_a, we_n_a;
    logic        ready_b, rv_b, re_b, busy_b, we_n_b;
    logic        ready_c, rv_c, re_c, busy_c, we_n_c;
    logic [15:0] rd_a, wd_a, rd_b, wd_b, rd_c, wd_c;
    logic [3:0]  sel_a, sel_c;
    logic [2:0]  sel_b;
    wire  [15:0] bus_a, bus_b, bus_c;

    logic [15:0] mem_a [4] = '{default: '0};
    logic [15:0] mem_b [3] = '{default: '0};
    logic [15:0] mem_c [4] = '{default: '0};

    int n_cmp = 0;
    int n_bad = 0;
    int viol  = 0;

    // Packed status: {ready, busy, rsp_valid, rsp_err, we_n, sel_n}
    logic [8:0] st_a, st_c;
    logic [7:0] st_b;
    assign st_a = {ready_a, busy_a, rv_a, re_a, we_n_a, sel_a};
    assign st_b = {ready_b, busy_b, rv_b, re_b, we_n_b, sel_b};
    assign st_c = {ready_c, busy_c, rv_c, re_c, we_n_c, sel_c};

    always #5 clk = ~clk;

    reg_bus_master #(.WIDTH(16), .NREGS(4), .ADDR_W(2), .RD_WAIT(0)) u_a (
        .clk(clk), .rst(rst), .cmd_valid(valid_a), .cmd_ready(ready_a), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rv_a), .rsp_err(re_a),
        .rsp_rdata(rd_a), .busy(busy_a), .bus_sel_n(sel_a), .bus_we_n(we_n_a),
        .bus_wdata(wd_a), .bus_rdata(bus_a));

    reg_bus_master #(.WIDTH(16), .NREGS(3), .ADDR_W(2), .RD_WAIT(2)) u_b (
        .clk(clk), .rst(rst), .cmd_valid(valid_b), .cmd_ready(ready_b), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rv_b), .rsp_err(re_b),
        .rsp_rdata(rd_b), .busy(busy_b), .bus_sel_n(sel_b), .bus_we_n(we_n_b),
        .bus_wdata(wd_b), .bus_rdata(bus_b));

    reg_bus_master #(.WIDTH(16), .NREGS(4), .ADDR_W(2), .RD_WAIT(3)) u_c (
        .clk(clk), .rst(rst), .cmd_valid(valid_c), .cmd_ready(ready_c), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rv_c), .rsp_err(re_c),
        .rsp_rdata(rd_c), .busy(busy_c), .bus_sel_n(sel_c), .bus_we_n(we_n_c),
        .bus_wdata(wd_c), .bus_rdata(bus_c));

    function automatic int low_idx(input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (!s[i]) return i;
        return 0;
    endfunction

    // Register targets: capture on the edge ending a write, float when deselected.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) if (!sel_a[i] && !we_n_a) mem_a[i] <= wd_a;
        for (int i = 0; i < 3; i++) if (!sel_b[i] && !we_n_b) mem_b[i] <= wd_b;
        for (int i = 0; i < 4; i++) if (!sel_c[i] && !we_n_c) mem_c[i] <= wd_c;
    end
    assign bus_a = (&sel_a) ? 16'hzzzz : mem_a[low_idx(sel_a)];
    assign bus_b = (&sel_b) ? 16'hzzzz : mem_b[low_idx({1'b1, sel_b})];
    assign bus_c = (&sel_c) ? 16'hzzzz : mem_c[low_idx(sel_c)];

    // Strobe safety watch: at most one select low; we_n low only with exactly one select.
    always @(negedge clk) begin
        if (!rst) begin
            if (!$onehot0(~sel_a) || (!we_n_a && !$onehot(~sel_a))) viol++;
            if (!$onehot0(~sel_b) || (!we_n_b && !$onehot(~sel_b))) viol++;
            if (!$onehot0(~sel_c) || (!we_n_c && !$onehot(~sel_c))) viol++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (st_a !== 9'b0_0_0_0_1_1111) begin n_bad++; $display("FAIL rst_st_a got=%b exp=%b", st_a, 9'b000011111); end
            n_cmp++; if (st_b !== 8'b0_0_0_0_1_111) begin n_bad++; $display("FAIL rst_st_b got=%b exp=%b", st_b, 8'b00001111); end
            n_cmp++; if ({rd_a, wd_a} !== 32'h0) begin n_bad++; $display("FAIL rst_data_a got=%h exp=0", {rd_a, wd_a}); end
        end
        rst = 1'b0;
        step();
        n_cmp++; if (st_a !== 9'b1_0_0_0_1_1111) begin n_bad++; $display("FAIL rst_release_a got=%b exp=%b", st_a, 9'b100011111); end
        n_cmp++; if (st_c !== 9'b1_0_0_0_1_1111) begin n_bad++; $display("FAIL rst_release_c got=%b exp=%b", st_c, 9'b100011111); end
    endtask

    task automatic test_write();
        valid_a = 1'b1; cmd_we = 1'b1; cmd_addr = 2'd1; cmd_wdata = 16'hAAAA;
        step();
        valid_a = 1'b0; cmd_we = 1'b0; cmd_addr = 2'd2; cmd_wdata = 16'h5555;
        n_cmp++; if (st_a !== 9'b0_1_0_0_0_1101) begin n_bad++; $display("FAIL wr_strobe got=%b exp=%b", st_a, 9'b010001101); end
        n_cmp++; if (wd_a !== 16'hAAAA) begin n_bad++; $display("FAIL wr_wdata got=%h exp=aaaa", wd_a); end
        step();
        n_cmp++; if (st_a !== 9'b0_1_1_0_1_1111) begin n_bad++; $display("FAIL wr_rsp got=%b exp=%b", st_a, 9'b011011111); end
        n_cmp++; if (rd_a !== 16'h0) begin n_bad++; $display("FAIL wr_rdata got=%h exp=0", rd_a); end
        n_cmp++; if (mem_a[1] !== 16'hAAAA) begin n_bad++; $display("FAIL wr_target got=%h exp=aaaa", mem_a[1]); end
        step();
        n_cmp++; if (st_a !== 9'b1_0_0_0_1_1111) begin n_bad++; $display("FAIL wr_idle got=%b exp=%b", st_a, 9'b100011111); end
    endtask

    task automatic test_read_hiz();
        valid_a = 1'b1; cmd_we = 1'b0; cmd_addr = 2'd1;
        step();
        valid_a = 1'b0;
        n_cmp++; if (st_a !== 9'b0_1_0_0_1_1101) begin n_bad++; $display("FAIL rd_strobe got=%b exp=%b", st_a, 9'b010011101); end
        n_cmp++; if (wd_a !== 16'hAAAA) begin n_bad++; $display("FAIL rd_wdata_hold got=%h exp=aaaa", wd_a); end
        step();
        n_cmp++; if (st_a !== 9'b0_1_1_0_1_1111) begin n_bad++; $display("FAIL rd_rsp got=%b exp=%b", st_a, 9'b011011111); end
        n_cmp++; if (rd_a !== 16'hAAAA) begin n_bad++; $display("FAIL rd_data got=%h exp=aaaa", rd_a); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (st_a !== 9'b1_0_0_0_1_1111) begin n_bad++; $display("FAIL hiz_st got=%b exp=%b", st_a, 9'b100011111); end
            n_cmp++; if (rd_a !== 16'hAAAA) begin n_bad++; $display("FAIL hiz_rdata got=%h exp=aaaa", rd_a); end
        end
    endtask

    task automatic test_patterns();
        logic [1:0]  p_addr [3] = '{2'd3, 2'd0, 2'd2};
        logic [15:0] p_data [3] = '{16'h5A5A, 16'h0F0F, 16'hFFFF};
        logic [3:0]  p_sel  [3] = '{4'b0111, 4'b1110, 4'b1011};
        for (int i = 0; i < 3; i++) begin
            valid_a = 1'b1; cmd_we = 1'b1; cmd_addr = p_addr[i]; cmd_wdata = p_data[i];
            step();
            valid_a = 1'b0;
            n_cmp++; if (st_a !== {5'b0_1_0_0_0, p_sel[i]}) begin n_bad++; $display("FAIL pat_wr_%0d got=%b exp=%b", i, st_a, {5'b01000, p_sel[i]}); end
            step();
            n_cmp++; if (rv_a !== 1'b1) begin n_bad++; $display("FAIL pat_wr_rsp_%0d got=%b exp=1", i, rv_a); end
            step();
        end
        for (int i = 2; i >= 0; i--) begin
            valid_a = 1'b1; cmd_we = 1'b0; cmd_addr = p_addr[i]; cmd_wdata = 16'h1111;
            step();
            valid_a = 1'b0;
            n_cmp++; if (st_a !== {5'b0_1_0_0_1, p_sel[i]}) begin n_bad++; $display("FAIL pat_rd_%0d got=%b exp=%b", i, st_a, {5'b01001, p_sel[i]}); end
            step();
            n_cmp++; if ({rv_a, rd_a} !== {1'b1, p_data[i]}) begin n_bad++; $display("FAIL pat_rd_data_%0d got=%h exp=%h", i, {rv_a, rd_a}, {1'b1, p_data[i]}); end
            step();
        end
    endtask

    task automatic test_invalid();
        valid_b = 1'b1; cmd_we = 1'b0; cmd_addr = 2'd3;
        step();
        valid_b = 1'b0;
        n_cmp++; if (st_b !== 8'b0_1_1_1_1_111) begin n_bad++; $display("FAIL inv_rd_rsp got=%b exp=%b", st_b, 8'b01111111); end
        n_cmp++; if (rd_b !== 16'h0) begin n_bad++; $display("FAIL inv_rd_rdata got=%h exp=0", rd_b); end
        step();
        n_cmp++; if (st_b !== 8'b1_0_0_0_1_111) begin n_bad++; $display("FAIL inv_rd_idle got=%b exp=%b", st_b, 8'b10001111); end
        valid_b = 1'b1; cmd_we = 1'b1; cmd_addr = 2'd3; cmd_wdata = 16'hDEAD;
        step();
        valid_b = 1'b0;
        n_cmp++; if (st_b !== 8'b0_1_1_1_1_111) begin n_bad++; $display("FAIL inv_wr_rsp got=%b exp=%b", st_b, 8'b01111111); end
        n_cmp++; if (wd_b !== 16'h0) begin n_bad++; $display("FAIL inv_wr_wdata got=%h exp=0", wd_b); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_st [8] = '{8'b0_1_0_0_0_110, 8'b0_1_1_0_1_111, 8'b1_0_0_0_1_111, 8'b0_1_0_0_1_110,
                                   8'b0_1_0_0_1_110, 8'b0_1_0_0_1_110, 8'b0_1_1_0_1_111, 8'b1_0_0_0_1_111};
        int rd_low = 0;
        valid_b = 1'b1; cmd_we = 1'b1; cmd_addr = 2'd0; cmd_wdata = 16'h1234;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++; if (st_b !== exp_st[i]) begin n_bad++; $display("FAIL b2b_st_%0d got=%b exp=%b", i, st_b, exp_st[i]); end
            if (i >= 3 && !ready_b) rd_low++;
            if (i == 0) begin cmd_we = 1'b0; cmd_wdata = 16'hFFFF; end
            if (i == 3) valid_b = 1'b0;
            if (i == 5) begin
                n_cmp++; if (wd_b !== 16'h1234) begin n_bad++; $display("FAIL b2b_wdata_hold got=%h exp=1234", wd_b); end
            end
            if (i == 6) begin
                n_cmp++; if (rd_b !== 16'h1234) begin n_bad++; $display("FAIL b2b_rdata got=%h exp=1234", rd_b); end
            end
        end
        n_cmp++; if (rd_low !== 4) begin n_bad++; $display("FAIL b2b_rd_ready_low got=%0d exp=4", rd_low); end
    endtask

    task automatic test_reset_mid_read();
        int seen_rsp = 0;
        int lat = 0;
        int sel_low = 0;
        valid_c = 1'b1; cmd_we = 1'b1; cmd_addr = 2'd2; cmd_wdata = 16'hBEEF;
        step(); valid_c = 1'b0; step(); step();
        valid_c = 1'b1; cmd_we = 1'b0; cmd_addr = 2'd2;
        step();
        valid_c = 1'b0;
        n_cmp++; if (st_c !== 9'b0_1_0_0_1_1011) begin n_bad++; $display("FAIL mid_rd1 got=%b exp=%b", st_c, 9'b010011011); end
        step();
        n_cmp++; if (st_c !== 9'b0_1_0_0_1_1011) begin n_bad++; $display("FAIL mid_rd2 got=%b exp=%b", st_c, 9'b010011011); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (st_c !== 9'b0_0_0_0_1_1111) begin n_bad++; $display("FAIL mid_rst got=%b exp=%b", st_c, 9'b000011111); end
        for (int i = 0; i < 6; i++) begin
            step();
            if (rv_c) seen_rsp++;
            if (i == 0) begin
                n_cmp++; if (st_c !== 9'b1_0_0_0_1_1111) begin n_bad++; $display("FAIL mid_release got=%b exp=%b", st_c, 9'b100011111); end
            end
        end
        n_cmp++; if (seen_rsp !== 0) begin n_bad++; $display("FAIL mid_no_rsp got=%0d exp=0", seen_rsp); end
        valid_c = 1'b1; cmd_we = 1'b1; cmd_addr = 2'd3; cmd_wdata = 16'h0C0C;
        step();
        valid_c = 1'b0;
        n_cmp++; if (st_c !== 9'b0_1_0_0_0_0111) begin n_bad++; $display("FAIL mid_new_wr got=%b exp=%b", st_c, 9'b010000111); end
        step();
        n_cmp++; if (st_c !== 9'b0_1_1_0_1_1111) begin n_bad++; $display("FAIL mid_new_rsp got=%b exp=%b", st_c, 9'b011011111); end
        step();
        valid_c = 1'b1; cmd_we = 1'b0; cmd_addr = 2'd3;
        lat = 11;
        for (int k = 1; k <= 10; k++) begin
            step();
            valid_c = 1'b0;
            if (sel_c !== 4'b1111) sel_low++;
            if (rv_c) begin lat = k; break; end
        end
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL mid_rd_latency got=%0d exp=5", lat); end
        n_cmp++; if (sel_low !== 4) begin n_bad++; $display("FAIL mid_rd_sel_cycles got=%0d exp=4", sel_low); end
        n_cmp++; if (rd_c !== 16'h0C0C) begin n_bad++; $display("FAIL mid_rd_data got=%h exp=0c0c", rd_c); end
        step();
    endtask

    task automatic test_strobe_monitor();
        n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL strobe_safety got=%0d exp=0", viol); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_hiz();
        test_patterns();
        test_invalid();
        test_back_to_back();
        test_reset_mid_read();
        test_strobe_monitor();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
